// File: rtl/div_share_pkg.sv
// Shared types and width helpers for the divider-sharing arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

    // The hold counter only ever holds CALC_CYCLES-1 down to 0.
    function automatic int cnt_width(input int calc_cycles);
        return (calc_cycles < 2) ? 1 : $clog2(calc_cycles);
    endfunction

endpackage

// File: rtl/div.sv
// Unsigned combinational divider (quotient/remainder) with divide-by-zero flag.
// Latency: purely combinational; callers hold operands for a multicycle window.
// Backpressure: none.
// Ports: a (dividend), b (divisor) -> quotient, remainder, divide_by_0.
// Divide by zero returns all-ones quotient and the low dividend bits as remainder.
module div #(
    parameter int a_width  = 8,
    parameter int b_width  = 8,
    parameter int tc_mode  = 0,
    parameter int rem_mode = 1
) (
    input  logic [a_width-1:0] a,
    input  logic [b_width-1:0] b,
    output logic [a_width-1:0] quotient,
    output logic [b_width-1:0] remainder,
    output logic               divide_by_0
);

    // Only the unsigned, remainder-style flavour is implemented; for unsigned
    // operands remainder and modulus coincide, but signed mode would not.
    if (tc_mode != 0 || rem_mode != 1 || a_width < b_width) begin : g_bad_cfg
        $error("div: only unsigned remainder mode with a_width >= b_width is supported");
    end

    logic [a_width-1:0] b_ext;

    always_comb begin
        b_ext       = a_width'(b);
        divide_by_0 = (b == '0);
        if (divide_by_0) begin
            quotient  = '1;
            remainder = b_width'(a);
        end else begin
            quotient  = a / b_ext;
            // Remainder is always < b, so truncation to b_width is lossless.
            remainder = b_width'(a % b_ext);
        end
    end

endmodule

// File: rtl/div_share_arbiter_rr_pick.sv
// Round-robin first-one search starting at ptr_i, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; grant_o is meaningful only when any_o is high.
// Ports: valid_i (per-requester valid), ptr_i (search start) -> grant_o, any_o.
module rr_pick
    import div_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] grant_o,
    output logic            any_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_o && valid_i[idx]) begin
                any_o   = 1'b1;
                grant_o = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one combinational divider among NREQ requesters: round-robin accept, hold, tagged reply.
// Latency: accept edge T -> rsp_valid high from edge T+CALC_CYCLES; period CALC_CYCLES+2.
// Backpressure: rsp_ready low stalls in RESP indefinitely with all req_ready low.
// Ports: req_valid/req_ready/req_a/req_b per requester; rsp_valid/rsp_ready/rsp_id/
//        rsp_quotient/rsp_remainder/rsp_div0 single response port; busy in CALC and RESP.
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int A_WIDTH     = 8,
    parameter int B_WIDTH     = 8,
    parameter int NREQ        = 4,
    parameter int CALC_CYCLES = 2,
    parameter int ID_W        = id_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*A_WIDTH-1:0] req_a,
    input  logic [NREQ*B_WIDTH-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [A_WIDTH-1:0]      rsp_quotient,
    output logic [B_WIDTH-1:0]      rsp_remainder,
    output logic                    rsp_div0,
    output logic                    busy
);

    localparam int CNT_W = cnt_width(CALC_CYCLES);

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic [ID_W-1:0]    id_q;

    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [A_WIDTH-1:0] rsp_quotient_q;
    logic [B_WIDTH-1:0] rsp_remainder_q;
    logic               rsp_div0_q;

    logic [ID_W-1:0]    grant;
    logic               any_vld;
    logic [ID_W-1:0]    ptr_d;

    logic [A_WIDTH-1:0] div_quot;
    logic [B_WIDTH-1:0] div_rem;
    logic               div_zero;

    // Unpack the flat operand buses so the granted requester can be indexed.
    logic [A_WIDTH-1:0] a_arr [NREQ];
    logic [B_WIDTH-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*A_WIDTH +: A_WIDTH];
        assign b_arr[i] = req_b[i*B_WIDTH +: B_WIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (any_vld)
    );

    // Operands come only from the registers, so the divider sees stable inputs
    // for the whole CALC window and can be timed as a multicycle path.
    div #(
        .a_width  (A_WIDTH),
        .b_width  (B_WIDTH),
        .tc_mode  (0),
        .rem_mode (1)
    ) u_div (
        .a           (a_q),
        .b           (b_q),
        .quotient    (div_quot),
        .remainder   (div_rem),
        .divide_by_0 (div_zero)
    );

    assign ptr_d = (grant == ID_W'(NREQ - 1)) ? '0 : grant + ID_W'(1);

    // Offer is combinational from the pick; gated by reset so nothing is
    // handshaken on a reset edge.
    always_comb begin
        req_ready = '0;
        if (reset_n && state_q == IDLE && any_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            cnt_q           <= '0;
            a_q             <= '0;
            b_q             <= '0;
            id_q            <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_div0_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        a_q     <= a_arr[grant];
                        b_q     <= b_arr[grant];
                        id_q    <= grant;
                        ptr_q   <= ptr_d;
                        cnt_q   <= CNT_W'(CALC_CYCLES - 1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        rsp_quotient_q  <= div_quot;
                        rsp_remainder_q <= div_rem;
                        rsp_div0_q      <= div_zero;
                        rsp_id_q        <= id_q;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    // Returning to IDLE here means the next accept is one cycle later.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_div0      = rsp_div0_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter: default instance (NREQ=4, CALC_CYCLES=2)
// and a small instance (NREQ=3, CALC_CYCLES=1).
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_div_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance 0: NREQ=4, CALC_CYCLES=2 ----------------
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_quotient;
    logic [7:0]  rsp_remainder;
    logic        rsp_div0;
    logic        busy;

    div_share_arbiter #(
        .A_WIDTH (8), .B_WIDTH (8), .NREQ (4), .CALC_CYCLES (2)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_div0      (rsp_div0),
        .busy          (busy)
    );

    // ---------------- instance 1: NREQ=3, CALC_CYCLES=1 ----------------
    logic        reset1_n;
    logic [2:0]  req1_valid;
    logic [2:0]  req1_ready;
    logic [23:0] req1_a;
    logic [23:0] req1_b;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [1:0]  rsp1_id;
    logic [7:0]  rsp1_quotient;
    logic [7:0]  rsp1_remainder;
    logic        rsp1_div0;
    logic        busy1;

    div_share_arbiter #(
        .A_WIDTH (8), .B_WIDTH (8), .NREQ (3), .CALC_CYCLES (1)
    ) u_dut1 (
        .clk           (clk),
        .reset_n       (reset1_n),
        .req_valid     (req1_valid),
        .req_ready     (req1_ready),
        .req_a         (req1_a),
        .req_b         (req1_b),
        .rsp_valid     (rsp1_valid),
        .rsp_ready     (rsp1_ready),
        .rsp_id        (rsp1_id),
        .rsp_quotient  (rsp1_quotient),
        .rsp_remainder (rsp1_remainder),
        .rsp_div0      (rsp1_div0),
        .busy          (busy1)
    );

    // Round-robin expectations, hand computed: a=100+i, b=i+1.
    logic [1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] rr_quo [5] = '{8'd100, 8'd50, 8'd34, 8'd25, 8'd100};
    logic [7:0] rr_rem [5] = '{8'd0, 8'd1, 8'd0, 8'd3, 8'd0};

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        reset1_n   = 1'b0;
        req1_valid = '0;
        req1_a     = '0;
        req1_b     = '0;
        rsp1_ready = 1'b1;

        // ---- reset state ----
        req_valid = 4'b1111;
        tick();
        tick();
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_quotient", rsp_quotient, 0);
        check_val("rst_remainder", rsp_remainder, 0);
        check_val("rst_id", rsp_id, 0);
        check_val("rst_div0", rsp_div0, 0);
        req_valid = '0;
        reset_n   = 1'b1;
        tick();
        check_val("idle_no_req_ready", req_ready, 0);

        // ---- single request: req 2, 200/7 ----
        req_valid     = 4'b0100;
        req_a[23:16]  = 8'd200;
        req_b[23:16]  = 8'd7;
        #1;
        check_val("single_req_ready", req_ready, 4'b0100);
        tick();                                   // accept edge T
        req_valid = '0;
        #1;
        check_val("single_busy_T", busy, 1);
        check_val("single_valid_T", rsp_valid, 0);
        tick();                                   // T+1
        check_val("single_busy_T1", busy, 1);
        check_val("single_valid_T1", rsp_valid, 0);
        tick();                                   // T+2
        check_val("single_valid_T2", rsp_valid, 1);
        check_val("single_busy_T2", busy, 1);
        check_val("single_quo", rsp_quotient, 28);
        check_val("single_rem", rsp_remainder, 4);
        check_val("single_div0", rsp_div0, 0);
        check_val("single_id", rsp_id, 2);
        tick();                                   // T+3
        check_val("single_valid_T3", rsp_valid, 0);
        check_val("single_busy_T3", busy, 0);

        // ---- divide by zero: req 0, 0x5A/0 (ptr is 3, wraps to 0) ----
        req_valid   = 4'b0001;
        req_a[7:0]  = 8'h5A;
        req_b[7:0]  = 8'h00;
        #1;
        check_val("div0_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        check_val("div0_valid", rsp_valid, 1);
        check_val("div0_quo", rsp_quotient, 8'hFF);
        check_val("div0_rem", rsp_remainder, 8'h5A);
        check_val("div0_flag", rsp_div0, 1);
        check_val("div0_id", rsp_id, 0);
        tick();

        // ---- reset mid-CALC: accept req 1 then reset ----
        req_valid   = 4'b0010;
        req_a[15:8] = 8'd100;
        req_b[15:8] = 8'd3;
        #1;
        check_val("rmid_req_ready", req_ready, 4'b0010);
        tick();                                   // accept
        req_valid = '0;
        reset_n   = 1'b0;
        tick();                                   // reset edge
        check_val("rmid_rsp_valid", rsp_valid, 0);
        check_val("rmid_busy", busy, 0);
        check_val("rmid_quo", rsp_quotient, 0);
        check_val("rmid_rem", rsp_remainder, 0);
        check_val("rmid_div0", rsp_div0, 0);
        check_val("rmid_id", rsp_id, 0);
        reset_n = 1'b1;
        tick();
        check_val("rmid_no_rsp", rsp_valid, 0);

        // ---- round robin: all valid, a=100+i, b=i+1; ptr must be 0 again ----
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(100 + i);
            req_b[i*8 +: 8] = 8'(i + 1);
        end
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            check_val($sformatf("rr%0d_grant", n), req_ready, 32'(4'b0001 << rr_id[n]));
            tick();
            check_val($sformatf("rr%0d_ready_calc", n), req_ready, 0);
            tick();
            tick();
            check_val($sformatf("rr%0d_valid", n), rsp_valid, 1);
            check_val($sformatf("rr%0d_id", n), rsp_id, rr_id[n]);
            check_val($sformatf("rr%0d_quo", n), rsp_quotient, rr_quo[n]);
            check_val($sformatf("rr%0d_rem", n), rsp_remainder, rr_rem[n]);
            check_val($sformatf("rr%0d_ready_resp", n), req_ready, 0);
            tick();
        end

        // ---- backpressure: next grant is 1 (101/2), stall 10 cycles ----
        rsp_ready = 1'b0;
        check_val("bp_grant", req_ready, 4'b0010);
        tick();                                   // accept
        req_a[15:8] = 8'd7;                       // must not affect result
        req_b[15:8] = 8'd9;
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            check_val("bp_valid", rsp_valid, 1);
            check_val("bp_quo", rsp_quotient, 50);
            check_val("bp_rem", rsp_remainder, 1);
            check_val("bp_id", rsp_id, 1);
            check_val("bp_ready_low", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_val("bp_release_valid", rsp_valid, 1);
        tick();
        check_val("bp_after_valid", rsp_valid, 0);
        check_val("bp_after_busy", busy, 0);
        check_val("bp_next_grant", req_ready, 4'b0100);
        req_valid = '0;
        tick();

        // ---- NREQ=3, CALC_CYCLES=1 instance ----
        reset1_n = 1'b1;
        tick();
        req1_valid   = 3'b010;
        req1_a[15:8] = 8'd10;
        req1_b[15:8] = 8'd3;
        #1;
        check_val("s_first_grant", req1_ready, 3'b010);
        tick();                                   // accept, ptr -> 2
        req1_valid = '0;
        tick();                                   // one cycle later
        check_val("s_lat1_valid", rsp1_valid, 1);
        check_val("s_lat1_quo", rsp1_quotient, 3);
        check_val("s_lat1_rem", rsp1_remainder, 1);
        tick();
        req1_valid    = 3'b110;
        req1_a[15:8]  = 8'd255;
        req1_b[15:8]  = 8'd16;
        req1_a[23:16] = 8'd255;
        req1_b[23:16] = 8'd16;
        #1;
        check_val("s_grant2", req1_ready, 3'b100);
        tick();
        tick();
        check_val("s_g2_valid", rsp1_valid, 1);
        check_val("s_g2_id", rsp1_id, 2);
        check_val("s_g2_quo", rsp1_quotient, 15);
        check_val("s_g2_rem", rsp1_remainder, 15);
        tick();
        check_val("s_grant1", req1_ready, 3'b010);
        tick();
        req1_valid = '0;
        tick();
        check_val("s_g1_valid", rsp1_valid, 1);
        check_val("s_g1_id", rsp1_id, 1);
        check_val("s_g1_quo", rsp1_quotient, 15);
        check_val("s_g1_rem", rsp1_remainder, 15);
        tick();
        check_val("s_idle_busy", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Round-robin arbiter and sequencer that shares one unsigned combinational divider (`div`, tc_mode=0, rem_mode=1) among NREQ requesters. It accepts one request at a time and registers the operands. It holds them stable for a fixed multicycle window so the divider's long combinational path can use a relaxed timing constraint. It then presents a tagged, registered result on a single valid/ready response port. It sits between the HPS-facing register/bridge logic and the divider datapath.

## Interface
- A_WIDTH, 8, dividend and quotient width
- B_WIDTH, 8, divisor and remainder width
- NREQ, 4, number of requesters (≥2)
- CALC_CYCLES, 2, cycles operands are held before result capture (≥1)
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*A_WIDTH  dividends, requester i at [i*A_WIDTH +: A_WIDTH]
- req_b  in  NREQ*B_WIDTH  divisors, requester i at [i*B_WIDTH +: B_WIDTH]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  ID_W=$clog2(NREQ)  index of the requester that owns the result
- rsp_quotient  out  A_WIDTH  registered quotient
- rsp_remainder  out  B_WIDTH  registered remainder
- rsp_div0  out  1  divisor was zero
- busy  out  1  high in CALC and RESP

## Operation
- FSM with three states: IDLE, CALC, RESP.
- **IDLE**
  - Grant = first i with req_valid[i], searching ptr, ptr+1, … modulo NREQ.
  - req_ready[grant] = 1 combinationally; no bit is high if there are no requests or the FSM is not in IDLE.
  - On valid&ready: latch a, b, id = grant; ptr <= grant+1 (wraps NREQ-1 → 0); cnt <= CALC_CYCLES-1; go to CALC.
- **CALC**
  - Latched operands drive `div`.
  - When cnt==0: capture quotient, remainder and divide_by_0 into the rsp_* registers, set rsp_valid, go to RESP.
  - Otherwise cnt decrements each cycle.
- **RESP**
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&rsp_ready: clear rsp_valid, go to IDLE.
  - No request is accepted in that same cycle.
- **Divide by zero:** rsp_quotient = all ones, rsp_remainder = a[B_WIDTH-1:0], rsp_div0 = 1. This case is not an error and needs no special sequencing.
- **Requester obligations:** hold req_valid, req_a and req_b stable until accepted. The arbiter does not re-sample operands after acceptance.
- **ptr behaviour:** ptr does not move when there is no grant. A lone active requester is granted back-to-back.
- **Fairness:** with all requesters permanently valid, the grant order is 0,1,…,NREQ-1,0,…

## Timing
- **Reset** (reset_n low at a clock edge): state IDLE, ptr 0, cnt 0, rsp_valid 0, rsp_id 0, rsp_quotient 0, rsp_remainder 0, rsp_div0 0, busy 0. req_ready is low during reset.
- **Reset mid-operation:** the in-flight transaction is dropped silently and no response is produced.
- **Latency:** accept edge at cycle T; rsp_valid is high from edge T+CALC_CYCLES.
- **Throughput:** if rsp_ready is held high, next accept edge is T+CALC_CYCLES+2. Period is CALC_CYCLES+2 cycles (4 with defaults).
- **Backpressure:** rsp_ready low stalls in RESP indefinitely. req_ready stays low for every requester during the stall.
- **Multicycle constraint:** the divider output is sampled only at the end of CALC. A multicycle constraint of CALC_CYCLES on the latched-operand → rsp_* paths is legal.
- **Late requests:** a request raised while busy is granted at the first IDLE cycle, subject to the rotation.
- **Input changes during CALC/RESP:** changes on req_a/req_b have no effect on the result.

## Structure
- Package `div_share_pkg`: state enum (IDLE, CALC, RESP), function computing ID_W from NREQ, and the CNT_W derivation for cnt.
- One sub-module: `rr_pick`, a combinational round-robin first-one search from ptr that outputs a grant index and an any_valid flag.
- The top instantiates `rr_pick`, the FSM/registers, and one `div` with a_width=A_WIDTH, b_width=B_WIDTH.

## Test plan
- **Single request:** req 2 with a=200, b=7, rsp_ready=1 → rsp_valid at accept+2; quotient 28, remainder 4, div0 0, id 2; busy for 3 cycles.
- **Divide by zero:** req 0 with a=0x5A, b=0 → quotient 0xFF, remainder 0x5A, div0 1.
- **Round-robin:** all four requesters valid continuously, with b=i+1 → grant/rsp_id order 0,1,2,3,0; one accept every 4 cycles; other req_ready bits always low.
- **Backpressure:** hold rsp_ready low for 10 cycles in RESP → rsp_* stable, req_ready all low; result released on rsp_ready high; IDLE on the next cycle.
- **Reset mid-CALC:** reset_n low one cycle after accept → no rsp_valid; all outputs 0; ptr 0, so requester 0 is granted first afterwards.
- **CALC_CYCLES=1, NREQ=3:** requesters 1 and 2 valid, ptr=2 → grant 2 then 1; a=255, b=16 gives quotient 15, remainder 15; latency 1 cycle.
